adder_sched: RTL
================

# adder_sched

Sequencing and arbitration front-end for the 16-bit adiabatic adder. Two requesters share the adder; `adder_sched` handles three things. It aligns each operation to the Bennett clock cycle boundary marked by `instFlag`. It holds the operands stable for one full Bennett cycle. It then captures `out`/`cout` and returns them with a valid/ready response. It sits between the request logic and the `adder` + `bennett_clock` pair, in the same `clk` domain as `bennett_clock`.

## Interface
- `WIDTH`, 16, operand/result width
- `TO_W`, 8, timeout counter width; timeout fires when the counter reaches 2^TO_W−1
- `clk`  in  1  system clock, same clock that drives `bennett_clock`
- `reset`  in  1  asynchronous, active-low reset
- `instFlag`  in  1  Bennett cycle-boundary flag from `bennett_clock`; same clock domain, no synchronizer
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted when valid&ready
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands
- `req0_cin`, `req1_cin`  in  1  carry-in
- `add_a`, `add_b`  out  WIDTH  operands driven to the adder
- `add_cin`  out  1  carry-in driven to the adder
- `add_out`  in  WIDTH  adder sum
- `add_cout`  in  1  adder carry-out
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  consumer accepts the response
- `resp_sum`  out  WIDTH  captured sum
- `resp_cout`  out  1  captured carry-out
- `resp_id`  out  1  requester index: 0 or 1
- `resp_err`  out  1  1 = operation timed out; sum and cout are 0

## Operation
- The `instFlag` rise is computed as `rise = instFlag & ~flag_q`, with `flag_q` a 1-cycle register of `instFlag`.
- **IDLE:**
  - `reqN_ready` is asserted combinationally for the granted requester only.
  - Grant is round-robin: the requester not served last wins a tie. The `last` pointer resets to 1, so req0 wins the first tie.
  - On accept: latch a/b/cin into `add_a/add_b/add_cin`, latch the id, clear the timeout counter, go to ALIGN.
- **ALIGN:** on `rise`, clear the counter and go to EVAL. A rise in the same cycle as the accept is not seen; the block waits for the next rise.
- **EVAL:**
  - On `rise`, capture `add_out`→`resp_sum` and `add_cout`→`resp_cout`.
  - Set `resp_err=0`, update `last` to the served id, go to RESP.
- **Timeout (ALIGN and EVAL):**
  - The counter increments every clk.
  - On reaching 2^TO_W−1 without a rise, go to RESP with `resp_err=1`, `resp_sum=0`, `resp_cout=0`.
  - `last` is still updated to the served id.
- **RESP:**
  - `resp_valid=1`. All `resp_*` outputs are held stable until `resp_valid & resp_ready`, then return to IDLE.
  - No request is accepted in ALIGN, EVAL or RESP.
- `add_a/add_b/add_cin` change only on accept. They hold their value in every other state, including IDLE after completion, so the adder sees no spurious transitions.
- Sum arithmetic is done entirely by the adder. The block performs no width extension; `resp_cout` is bit WIDTH of a+b+cin.

## Timing
- Reset (async assert, sync deassert via `clk`) sets:
  - state IDLE
  - `add_a=0`, `add_b=0`, `add_cin=0`
  - `resp_valid=0`, `resp_sum=0`, `resp_cout=0`, `resp_id=0`, `resp_err=0`
  - `last=1`, `flag_q=0`, counter 0
  - `reqN_ready` is 0 during reset.
- Reset asserted mid-operation aborts it. No response is produced and the adder operands return to 0.
- Latency from accept to `resp_valid`:
  - (clk cycles to the next `rise`) + (one Bennett period) + 1 clk.
  - `resp_valid` rises in the clk after the capturing `rise` is registered.
- Best-case throughput: one operation per two Bennett periods plus the response handshake.
- `resp_ready` may be high before `resp_valid`. In that case the response completes in the first RESP cycle, and IDLE can accept a new request on the following clk.
- If both requests are valid, exactly one `ready` is high. The losing request must stay valid with operands stable until it is granted.

## Test plan
- Single request: req0 `000F`+`0001`, cin=0 → `resp_sum=0010`, `resp_cout=0`, `resp_id=0`, `resp_err=0`. `add_a` stays `000F` from accept through RESP.
- Simultaneous requests:
  - req0 `0011`+`FF11`+1 and req1 `FFFF`+`FFFF`+0 both valid out of reset.
  - First response: id 0, `FF23`, cout 0.
  - Second response: id 1, `FFFE`, cout 1.
  - A repeated tie after that grants req0 again; alternation holds under continuous requests.
- Alignment: accept req1 `1234`+`5678`+1 in the same cycle as an `instFlag` rise → capture happens on the second following rise, not the first. Result `68AD`, cout 0.
- Timeout: hold `instFlag` low after accept, TO_W=8 → after 255 clks `resp_valid=1`, `resp_err=1`, `resp_sum=0000`.
- Backpressure: hold `resp_ready=0` for 50 clks → `resp_*` stable, both `reqN_ready=0`. Raise `resp_ready` → IDLE on the next clk.
- Reset mid-EVAL: pull `reset` low → `resp_valid=0` and `add_a=0` immediately, with no response. After release, a new req0 `000F`+`0001` completes correctly with `0010`.

Source files
------------

// File: rtl/adder_sched.sv
// adder_sched -- sequencing and arbitration front-end for the 16-bit adiabatic adder.
//
// Two requesters share one adder. An accepted operation waits for the next
// Bennett cycle boundary (rising edge of instFlag). Its operands are then held
// stable for one full Bennett period. The adder result is captured on the
// following boundary and returned through a valid/ready response port. If no
// boundary arrives within 2^TO_W-1 clocks, the operation ends with resp_err set.
//
// Ports
//   clk                      system clock, shared with bennett_clock
//   reset                    asynchronous active-low reset (released synchronously)
//   instFlag                 Bennett cycle-boundary flag, same clock domain
//   reqN_valid / reqN_ready  request handshake, N = 0,1 (ready is combinational)
//   reqN_a, reqN_b, reqN_cin request operands
//   add_a, add_b, add_cin    operands driven to the adder (change only on accept)
//   add_out, add_cout        adder sum and carry-out
//   resp_valid / resp_ready  response handshake
//   resp_sum, resp_cout      captured result
//   resp_id                  index of the served requester
//   resp_err                 1 = timed out; sum and cout are 0
module adder_sched #(
    parameter int WIDTH = 16,
    parameter int TO_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instFlag,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_out,
    input  logic             add_cout,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout,
    output logic             resp_id,
    output logic             resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_EVAL  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0]  CNT_ZERO  = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]  CNT_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
    // The count that, once incremented, would reach 2^TO_W-1: timeout fires here.
    localparam logic [TO_W-1:0]  CNT_LAST  = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    state_t           state_r, state_nxt_s;
    logic             flag_q_r;
    logic [TO_W-1:0]  cnt_r, cnt_nxt_s;
    logic             last_r, last_nxt_s;
    logic             id_r, id_nxt_s;
    logic [WIDTH-1:0] add_a_r, add_a_nxt_s;
    logic [WIDTH-1:0] add_b_r, add_b_nxt_s;
    logic             add_cin_r, add_cin_nxt_s;
    logic             resp_valid_r, resp_valid_nxt_s;
    logic [WIDTH-1:0] resp_sum_r, resp_sum_nxt_s;
    logic             resp_cout_r, resp_cout_nxt_s;
    logic             resp_id_r, resp_id_nxt_s;
    logic             resp_err_r, resp_err_nxt_s;
    logic             rise_s;
    logic             idle_s;

    // Reset synchronizer: assertion is immediate, release follows clk by two edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // A boundary is the first clk in which instFlag is seen high.
    assign rise_s = instFlag & ~flag_q_r;

    // Ready only in IDLE and out of reset; on a tie the requester not served last wins.
    assign idle_s     = rst_n_s & (state_r == ST_IDLE);
    assign req0_ready = idle_s & req0_valid & (~req1_valid | last_r);
    assign req1_ready = idle_s & req1_valid & (~req0_valid | ~last_r);

    // FSM state register plus all datapath registers loaded from the next-state logic.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r      <= ST_IDLE;
            flag_q_r     <= 1'b0;
            cnt_r        <= CNT_ZERO;
            last_r       <= 1'b1;
            id_r         <= 1'b0;
            add_a_r      <= DATA_ZERO;
            add_b_r      <= DATA_ZERO;
            add_cin_r    <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_sum_r   <= DATA_ZERO;
            resp_cout_r  <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            flag_q_r     <= instFlag;
            cnt_r        <= cnt_nxt_s;
            last_r       <= last_nxt_s;
            id_r         <= id_nxt_s;
            add_a_r      <= add_a_nxt_s;
            add_b_r      <= add_b_nxt_s;
            add_cin_r    <= add_cin_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_sum_r   <= resp_sum_nxt_s;
            resp_cout_r  <= resp_cout_nxt_s;
            resp_id_r    <= resp_id_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
        end
    end

    // Next-state and datapath logic; every register holds unless a state explicitly loads it.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        last_nxt_s       = last_r;
        id_nxt_s         = id_r;
        add_a_nxt_s      = add_a_r;
        add_b_nxt_s      = add_b_r;
        add_cin_nxt_s    = add_cin_r;
        resp_valid_nxt_s = resp_valid_r;
        resp_sum_nxt_s   = resp_sum_r;
        resp_cout_nxt_s  = resp_cout_r;
        resp_id_nxt_s    = resp_id_r;
        resp_err_nxt_s   = resp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (req1_ready) begin
                    add_a_nxt_s   = req1_a;
                    add_b_nxt_s   = req1_b;
                    add_cin_nxt_s = req1_cin;
                    id_nxt_s      = 1'b1;
                    cnt_nxt_s     = CNT_ZERO;
                    state_nxt_s   = ST_ALIGN;
                end else if (req0_ready) begin
                    add_a_nxt_s   = req0_a;
                    add_b_nxt_s   = req0_b;
                    add_cin_nxt_s = req0_cin;
                    id_nxt_s      = 1'b0;
                    cnt_nxt_s     = CNT_ZERO;
                    state_nxt_s   = ST_ALIGN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                if (rise_s) begin
                    // Operands have been stable since accept; the adder now gets a full period.
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_EVAL;
                end else if (cnt_r == CNT_LAST) begin
                    resp_valid_nxt_s = 1'b1;
                    resp_sum_nxt_s   = DATA_ZERO;
                    resp_cout_nxt_s  = 1'b0;
                    resp_err_nxt_s   = 1'b1;
                    resp_id_nxt_s    = id_r;
                    last_nxt_s       = id_r;
                    state_nxt_s      = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_EVAL: begin
                if (rise_s) begin
                    resp_valid_nxt_s = 1'b1;
                    resp_sum_nxt_s   = add_out;
                    resp_cout_nxt_s  = add_cout;
                    resp_err_nxt_s   = 1'b0;
                    resp_id_nxt_s    = id_r;
                    last_nxt_s       = id_r;
                    state_nxt_s      = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    resp_valid_nxt_s = 1'b1;
                    resp_sum_nxt_s   = DATA_ZERO;
                    resp_cout_nxt_s  = 1'b0;
                    resp_err_nxt_s   = 1'b1;
                    resp_id_nxt_s    = id_r;
                    last_nxt_s       = id_r;
                    state_nxt_s      = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_nxt_s = 1'b0;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    resp_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign add_a      = add_a_r;
    assign add_b      = add_b_r;
    assign add_cin    = add_cin_r;
    assign resp_valid = resp_valid_r;
    assign resp_sum   = resp_sum_r;
    assign resp_cout  = resp_cout_r;
    assign resp_id    = resp_id_r;
    assign resp_err   = resp_err_r;

endmodule
